// File: rtl/rgb565_pkg.sv
// Shared constants for the RGB565 frame writer: quantisation modes, FSM states
// and the 2x2 ordered-dither (Bayer) threshold table.
package rgb565_pkg;

    localparam logic [1:0] QMODE_TRUNC  = 2'd0;
    localparam logic [1:0] QMODE_ROUND  = 2'd1;
    localparam logic [1:0] QMODE_DITHER = 2'd2;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Entry k holds the threshold for position index {y[0],x[0]} = k
    localparam logic [7:0] BAYER_TABLE = {2'd1, 2'd3, 2'd2, 2'd0};

    function automatic logic [1:0] bayer_lookup(input logic [1:0] idx);
        return BAYER_TABLE[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/rgb565_quantizer.sv
// Combinational 8-bit to 5/6-bit channel quantiser supporting truncate,
// round-half-up with saturation and 2x2 ordered dither.
module rgb565_quantizer
    import rgb565_pkg::*;
(
    input  logic [7:0] chan,
    input  logic       wide,
    input  logic [1:0] mode,
    input  logic [1:0] bayer_idx,
    output logic [5:0] q
);

    logic [1:0] bayer_val;
    logic [8:0] bias;
    logic [8:0] sum;
    logic [8:0] shifted;

    // The 9-bit sum keeps the carry so an overflowing channel saturates
    // instead of wrapping back to black.
    always_comb begin
        bayer_val = bayer_lookup(bayer_idx);
        bias      = '0;
        case (mode)
            QMODE_ROUND:  bias = wide ? 9'd2 : 9'd4;
            QMODE_DITHER: bias = wide ? {7'd0, bayer_val} : {6'd0, bayer_val, 1'b0};
            default:      bias = '0;
        endcase
        sum     = {1'b0, chan} + bias;
        shifted = wide ? (sum >> 2) : (sum >> 3);
        if (wide) begin
            q = (shifted > 9'd63) ? 6'd63 : shifted[5:0];
        end else begin
            q = (shifted > 9'd31) ? 6'd31 : {1'b0, shifted[4:0]};
        end
    end

endmodule

// File: rtl/rgb565_frame_writer.sv
// RGB888 to RGB565 frame writer: tracks x/y and a linear frame-buffer address,
// re-aligns on start-of-frame and flags frame completion and sync errors.
module rgb565_frame_writer
    import rgb565_pkg::*;
#(
    parameter int IMG_W = 480,
    parameter int IMG_H = 272,
    parameter int QMODE = 0,
    localparam int ADDR_WIDTH = $clog2(IMG_W * IMG_H)
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  i_Clk_en,
    input  logic [23:0]           i_data_rgb888,
    input  logic                  i_valid,
    input  logic                  i_sof,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [15:0]           o_data,
    output logic                  o_valid,
    output logic                  o_frame_done,
    output logic                  o_sync_err,
    output logic                  o_busy
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [1:0]    MODE   = 2'(QMODE);

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  accept;
    logic                  write;
    logic                  restart;
    logic                  done_d;
    logic                  err_d;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [1:0]            bayer_pos;
    logic [5:0]            q_r, q_g, q_b;
    logic                  unused_bits;

    assign accept = i_Clk_en & i_valid;

    // Next-state and counter logic; a restart (SOF) forces the pixel to (0,0)
    // so the dither pattern and address both re-align with the new frame.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        write   = 1'b0;
        restart = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_addr = addr_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (i_sof) begin
                        write   = 1'b1;
                        restart = 1'b1;
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    write = 1'b1;
                    if (i_sof && !(x_q == '0 && y_q == '0)) begin
                        restart = 1'b1;
                        err_d   = 1'b1;
                    end else if (x_q == X_LAST && y_q == Y_LAST) begin
                        done_d  = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                        state_d = IDLE;
                    end else if (x_q == X_LAST) begin
                        x_d    = '0;
                        y_d    = y_q + YW'(1);
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end else begin
                        x_d    = x_q + XW'(1);
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            if (restart) begin
                wr_addr = '0;
                x_d     = XW'(1);
                y_d     = '0;
                addr_d  = ADDR_WIDTH'(1);
            end
        end
        bayer_pos = restart ? 2'b00 : {y_q[0], x_q[0]};
    end

    rgb565_quantizer u_quant_r (
        .chan      (i_data_rgb888[23:16]),
        .wide      (1'b0),
        .mode      (MODE),
        .bayer_idx (bayer_pos),
        .q         (q_r)
    );

    rgb565_quantizer u_quant_g (
        .chan      (i_data_rgb888[15:8]),
        .wide      (1'b1),
        .mode      (MODE),
        .bayer_idx (bayer_pos),
        .q         (q_g)
    );

    rgb565_quantizer u_quant_b (
        .chan      (i_data_rgb888[7:0]),
        .wide      (1'b0),
        .mode      (MODE),
        .bayer_idx (bayer_pos),
        .q         (q_b)
    );

    assign unused_bits = q_r[5] ^ q_b[5];

    // State, counters and the output register stage all freeze without clock enable
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            o_addr       <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
            o_busy       <= 1'b0;
        end else if (i_Clk_en) begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            o_valid      <= write;
            o_frame_done <= done_d;
            o_sync_err   <= err_d;
            o_busy       <= (state_d == ACTIVE);
            if (write) begin
                o_addr <= wr_addr;
                o_data <= {q_r[4:0], q_g, q_b[4:0]};
            end
        end
    end

endmodule

// File: tb/tb_rgb565_frame_writer.sv
// Scoreboard bench: three writers (truncate, round, dither) on a 4x2 frame
// share one stimulus stream and are checked against a behavioural model.
module tb_rgb565_frame_writer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;

    typedef struct packed {
        logic [AW-1:0]      addr;
        logic [2:0][15:0]   data;
        logic               done;
        logic               err;
    } expect_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          clkEn;
    logic          valid;
    logic          sof;
    logic [23:0]   pixel;

    logic [AW-1:0] dutAddr  [3];
    logic [15:0]   dutData  [3];
    logic          dutValid [3];
    logic          dutDone  [3];
    logic          dutErr   [3];
    logic          dutBusy  [3];

    expect_t       scoreboard[$];
    expect_t       held;
    bit            expValid, expDone, expErr, expBusy;
    bit            mActive;
    int            mx, my;
    int            checkCount = 0;
    int            failCount  = 0;

    always #5 clock = ~clock;

    rgb565_frame_writer #(.IMG_W(W), .IMG_H(H), .QMODE(0)) u_trunc (
        .iClk(clock), .iRst(reset), .i_Clk_en(clkEn), .i_data_rgb888(pixel),
        .i_valid(valid), .i_sof(sof), .o_addr(dutAddr[0]), .o_data(dutData[0]),
        .o_valid(dutValid[0]), .o_frame_done(dutDone[0]), .o_sync_err(dutErr[0]),
        .o_busy(dutBusy[0])
    );

    rgb565_frame_writer #(.IMG_W(W), .IMG_H(H), .QMODE(1)) u_round (
        .iClk(clock), .iRst(reset), .i_Clk_en(clkEn), .i_data_rgb888(pixel),
        .i_valid(valid), .i_sof(sof), .o_addr(dutAddr[1]), .o_data(dutData[1]),
        .o_valid(dutValid[1]), .o_frame_done(dutDone[1]), .o_sync_err(dutErr[1]),
        .o_busy(dutBusy[1])
    );

    rgb565_frame_writer #(.IMG_W(W), .IMG_H(H), .QMODE(2)) u_dither (
        .iClk(clock), .iRst(reset), .i_Clk_en(clkEn), .i_data_rgb888(pixel),
        .i_valid(valid), .i_sof(sof), .o_addr(dutAddr[2]), .o_data(dutData[2]),
        .o_valid(dutValid[2]), .o_frame_done(dutDone[2]), .o_sync_err(dutErr[2]),
        .o_busy(dutBusy[2])
    );

    // Reference quantisation straight from the arithmetic definition
    function automatic int quant(input int c, input int n, input int mode, input int bay);
        int v;
        if (mode == 0) v = c >> (8 - n);
        else if (mode == 1) v = (c + (1 << (7 - n))) >> (8 - n);
        else v = (c + ((n == 6) ? bay : 2 * bay)) >> (8 - n);
        if (v > (1 << n) - 1) v = (1 << n) - 1;
        return v;
    endfunction

    function automatic logic [15:0] toRgb565(input logic [23:0] p, input int mode, input int x, input int y);
        int bay, r, g, b;
        case ({y[0], x[0]})
            2'b00:   bay = 0;
            2'b01:   bay = 2;
            2'b10:   bay = 3;
            default: bay = 1;
        endcase
        r = quant(int'(p[23:16]), 5, mode, bay);
        g = quant(int'(p[15:8]), 6, mode, bay);
        b = quant(int'(p[7:0]), 5, mode, bay);
        return {r[4:0], g[5:0], b[4:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkCycle();
        expect_t e;
        if (clkEn && dutValid[0]) begin
            if (scoreboard.size() == 0) begin
                checkOutput("spurious_write", 32'd1, 32'd0);
            end else begin
                e = scoreboard.pop_front();
                held = e;
            end
        end
        checkOutput("pending", 32'(scoreboard.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("valid[%0d]", i), 32'(dutValid[i]), 32'(expValid));
            checkOutput($sformatf("done[%0d]", i), 32'(dutDone[i]), 32'(expDone));
            checkOutput($sformatf("sync_err[%0d]", i), 32'(dutErr[i]), 32'(expErr));
            checkOutput($sformatf("busy[%0d]", i), 32'(dutBusy[i]), 32'(expBusy));
            checkOutput($sformatf("addr[%0d]", i), 32'(dutAddr[i]), 32'(held.addr));
            checkOutput($sformatf("data[%0d]", i), 32'(dutData[i]), 32'(held.data[i]));
        end
    endtask

    task automatic applyStimulus(input logic [23:0] pix, input bit s, input bit v, input bit en);
        expect_t e;
        bit wr = 1'b0;
        int wx = 0, wy = 0;
        e = '0;
        pixel = pix;
        sof   = s;
        valid = v;
        clkEn = en;
        if (en && v) begin
            if (!mActive) begin
                if (s) begin
                    wr = 1'b1; mActive = 1'b1; mx = 1; my = 0;
                end
            end else if (s && !(mx == 0 && my == 0)) begin
                wr = 1'b1; e.err = 1'b1; mx = 1; my = 0;
            end else begin
                wr = 1'b1; wx = mx; wy = my;
                if (mx == W - 1 && my == H - 1) begin
                    e.done = 1'b1; mx = 0; my = 0; mActive = 1'b0;
                end else if (mx == W - 1) begin
                    mx = 0; my++;
                end else begin
                    mx++;
                end
            end
        end
        if (wr) begin
            e.addr = AW'(wy * W + wx);
            for (int m = 0; m < 3; m++) e.data[m] = toRgb565(pix, m, wx, wy);
            scoreboard.push_back(e);
        end
        if (en) begin
            expValid = wr;
            expDone  = wr && e.done;
            expErr   = wr && e.err;
            expBusy  = mActive;
        end
        @(posedge clock);
        #1;
        checkCycle();
    endtask

    task automatic doReset(input bit withPixel);
        reset = 1'b1;
        clkEn = 1'b1;
        valid = withPixel;
        sof   = 1'b0;
        pixel = 24'hABCDEF;
        mActive = 1'b0; mx = 0; my = 0;
        scoreboard.delete();
        held = '0;
        expValid = 1'b0; expDone = 1'b0; expErr = 1'b0; expBusy = 1'b0;
        @(posedge clock);
        #1;
        checkCycle();
        reset = 1'b0;
        valid = 1'b0;
    endtask

    function automatic logic [23:0] patternPixel(input int i);
        return 24'((i * 32'h00A3_5B1D) ^ 32'h0037_C2E4);
    endfunction

    initial begin
        reset = 1'b1; clkEn = 1'b0; valid = 1'b0; sof = 1'b0; pixel = '0;
        doReset(1'b0);

        // Frame 1: quantiser reference points at specific positions
        applyStimulus(24'hFF8844, 1'b1, 1'b1, 1'b1);
        checkOutput("ref_trunc_ff8844", 32'(dutData[0]), 32'h0000FC48);
        checkOutput("ref_round_ff8844", 32'(dutData[1]), 32'h0000FC49);
        checkOutput("ref_addr0", 32'(dutAddr[0]), 32'd0);
        applyStimulus(24'h040204, 1'b0, 1'b1, 1'b1);
        checkOutput("ref_dither_x1", 32'(dutData[2]), 32'h00000821);
        applyStimulus(24'h848684, 1'b0, 1'b1, 1'b1);
        checkOutput("ref_round_848684", 32'(dutData[1]), 32'h00008C51);
        checkOutput("ref_trunc_848684", 32'(dutData[0]), 32'h00008430);
        applyStimulus(24'h123456, 1'b0, 1'b1, 1'b1);
        applyStimulus(24'hFFFFFF, 1'b0, 1'b1, 1'b1);
        checkOutput("ref_dither_sat", 32'(dutData[2]), 32'h0000FFFF);
        applyStimulus(24'h040204, 1'b0, 1'b1, 1'b1);
        applyStimulus(24'h7F7F7F, 1'b0, 1'b1, 1'b1);
        applyStimulus(24'h808080, 1'b0, 1'b1, 1'b1);
        checkOutput("ref_done_addr7", 32'({dutDone[0], dutAddr[0]}), 32'h0000000F);
        applyStimulus(24'h111111, 1'b0, 1'b1, 1'b1);

        // Dither at (0,0) after a fresh SOF, then a frame ending back-to-back
        applyStimulus(24'h040204, 1'b1, 1'b1, 1'b1);
        checkOutput("ref_dither_x0", 32'(dutData[2]), 32'h00000000);
        for (int i = 1; i < 8; i++) applyStimulus(patternPixel(i), 1'b0, 1'b1, 1'b1);

        // Next frame starts immediately; re-SOF at address 5
        for (int i = 0; i < 5; i++) applyStimulus(patternPixel(i + 20), i == 0, 1'b1, 1'b1);
        applyStimulus(24'h5A5A5A, 1'b1, 1'b1, 1'b1);
        checkOutput("resync_addr", 32'(dutAddr[0]), 32'd0);
        for (int i = 1; i < 8; i++) applyStimulus(patternPixel(i + 40), 1'b0, 1'b1, 1'b1);

        // SOF on the last pixel: sync wins over frame done
        for (int i = 0; i < 7; i++) applyStimulus(patternPixel(i + 60), i == 0, 1'b1, 1'b1);
        applyStimulus(24'hC0FFEE, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++) applyStimulus(patternPixel(i + 80), 1'b0, 1'b1, 1'b1);

        // Clock enable toggling with valid held high
        for (int i = 0; i < 18; i++) applyStimulus(patternPixel(i + 100), i < 2, 1'b1, (i % 2) == 0);
        applyStimulus(24'h000000, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame, then data without SOF is ignored until a new frame
        for (int i = 0; i < 3; i++) applyStimulus(patternPixel(i + 130), i == 0, 1'b1, 1'b1);
        doReset(1'b1);
        applyStimulus(24'h246810, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(patternPixel(i + 150), i == 0, 1'b1, 1'b1);
        applyStimulus(24'h000000, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
